lcd_timing: RTL and testbench

LCD_TIMING -- requirements
Module: lcd_timing

---
 rtl/lcd_timing_pkg.sv | 49 ++++
 rtl/lcd_timing_sig_delay.sv | 32 +++
 rtl/lcd_timing.sv | 120 ++++++++++++
 tb/tb_lcd_timing.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_timing_pkg.sv
// Shared constants and types for the LCD timing generator.
// Holds the default panel timing (800x480 with porches), the derived
// totals/active-start values, counter widths and the sync/de bundle type.
package lcd_timing_pkg;

  localparam int unsigned H_ACTIVE_DEF   = 800;
  localparam int unsigned H_SYNC_DEF     = 20;
  localparam int unsigned H_BP_DEF       = 26;
  localparam int unsigned H_FP_DEF       = 210;
  localparam int unsigned V_ACTIVE_DEF   = 480;
  localparam int unsigned V_SYNC_DEF     = 3;
  localparam int unsigned V_BP_DEF       = 20;
  localparam int unsigned V_FP_DEF       = 22;
  localparam int unsigned PIPE_DELAY_DEF = 1;

  localparam int unsigned H_CNT_W = 11;
  localparam int unsigned V_CNT_W = 10;
  localparam int unsigned XY_W    = 10;

  typedef logic [H_CNT_W-1:0] h_cnt_t;
  typedef logic [V_CNT_W-1:0] v_cnt_t;

  // hsync/vsync are active-low, so the idle bundle has both high.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, de: 1'b0};

  function automatic int unsigned span_total(input int unsigned sync_w,
                                             input int unsigned bp,
                                             input int unsigned active,
                                             input int unsigned fp);
    return sync_w + bp + active + fp;
  endfunction

  function automatic int unsigned act_start(input int unsigned sync_w,
                                            input int unsigned bp);
    return sync_w + bp;
  endfunction

  localparam int unsigned H_TOTAL_DEF     = span_total(H_SYNC_DEF, H_BP_DEF, H_ACTIVE_DEF, H_FP_DEF);
  localparam int unsigned V_TOTAL_DEF     = span_total(V_SYNC_DEF, V_BP_DEF, V_ACTIVE_DEF, V_FP_DEF);
  localparam int unsigned H_ACT_START_DEF = act_start(H_SYNC_DEF, H_BP_DEF);
  localparam int unsigned V_ACT_START_DEF = act_start(V_SYNC_DEF, V_BP_DEF);

endpackage

// File: rtl/lcd_timing_sig_delay.sv
// sig_delay: DEPTH-stage shift register with async active-low reset to
// RST_VAL. DEPTH=0 is a plain pass-through.
// Ports: clk, nrst, d[WIDTH] in, q[WIDTH] out.
module sig_delay #(
  parameter int unsigned      WIDTH   = 1,
  parameter int unsigned      DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_bypass
    assign q = d;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      end else begin
        stage[0] <= d;
        for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/lcd_timing.sv
// lcd_timing: raster timing generator for a parallel-RGB LCD panel.
// Ports: clk (pixel clock), nrst (async active-low, may be unsynchronised),
// hsync/vsync (active-low), de (visible pixel), frame (1-cycle pulse after
// the last visible line), x/y (visible column/line, 0 outside the picture).
// hsync/vsync/de are delayed by PIPE_DELAY cycles; x/y/frame are not.
module lcd_timing
  import lcd_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
  parameter int unsigned H_SYNC     = H_SYNC_DEF,
  parameter int unsigned H_BP       = H_BP_DEF,
  parameter int unsigned H_FP       = H_FP_DEF,
  parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
  parameter int unsigned V_SYNC     = V_SYNC_DEF,
  parameter int unsigned V_BP       = V_BP_DEF,
  parameter int unsigned V_FP       = V_FP_DEF,
  parameter int unsigned PIPE_DELAY = PIPE_DELAY_DEF
) (
  input  logic            clk,
  input  logic            nrst,
  output logic            hsync,
  output logic            vsync,
  output logic            de,
  output logic            frame,
  output logic [XY_W-1:0] x,
  output logic [XY_W-1:0] y
);

  localparam h_cnt_t H_MAX      = h_cnt_t'(span_total(H_SYNC, H_BP, H_ACTIVE, H_FP) - 1);
  localparam h_cnt_t H_SYNC_END = h_cnt_t'(H_SYNC);
  localparam h_cnt_t H_ACT_BEG  = h_cnt_t'(act_start(H_SYNC, H_BP));
  localparam h_cnt_t H_ACT_END  = h_cnt_t'(act_start(H_SYNC, H_BP) + H_ACTIVE);

  localparam v_cnt_t V_MAX      = v_cnt_t'(span_total(V_SYNC, V_BP, V_ACTIVE, V_FP) - 1);
  localparam v_cnt_t V_SYNC_END = v_cnt_t'(V_SYNC);
  localparam v_cnt_t V_ACT_BEG  = v_cnt_t'(act_start(V_SYNC, V_BP));
  localparam v_cnt_t V_ACT_END  = v_cnt_t'(act_start(V_SYNC, V_BP) + V_ACTIVE);

  logic [1:0]      rst_sync;
  logic            run;
  h_cnt_t          h_cnt;
  v_cnt_t          v_cnt;
  logic            h_act;
  logic            v_act;
  sync_t           raw_d;
  sync_t           raw_q;
  sync_t           dly_q;
  logic [XY_W-1:0] x_d;
  logic [XY_W-1:0] y_d;
  logic            frame_d;

  // Release is synchronised; assertion stays asynchronous.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) rst_sync <= '0;
    else       rst_sync <= {rst_sync[0], 1'b1};
  end

  assign run = rst_sync[1];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (run) begin
      if (h_cnt == H_MAX) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_MAX) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Decode of the current counter position; registered below, so the ports
  // show position N on the cycle after the counters hold N.
  always_comb begin
    h_act         = (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END);
    v_act         = (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
    raw_d.hsync   = (h_cnt >= H_SYNC_END);
    raw_d.vsync   = (v_cnt >= V_SYNC_END);
    raw_d.de      = h_act && v_act;
    x_d           = '0;
    y_d           = '0;
    if (raw_d.de) begin
      x_d = XY_W'(h_cnt - H_ACT_BEG);
      y_d = XY_W'(v_cnt - V_ACT_BEG);
    end
    frame_d       = (h_cnt == '0) && (v_cnt == V_ACT_END);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      raw_q <= SYNC_IDLE;
      x     <= '0;
      y     <= '0;
      frame <= 1'b0;
    end else if (run) begin
      raw_q <= raw_d;
      x     <= x_d;
      y     <= y_d;
      frame <= frame_d;
    end
  end

  sig_delay #(
    .WIDTH  ($bits(sync_t)),
    .DEPTH  (PIPE_DELAY),
    .RST_VAL(SYNC_IDLE)
  ) u_sync_dly (
    .clk (clk),
    .nrst(nrst),
    .d   (raw_q),
    .q   (dly_q)
  );

  assign hsync = dly_q.hsync;
  assign vsync = dly_q.vsync;
  assign de    = dly_q.de;

endmodule

// File: tb/tb_lcd_timing.sv
module tb_lcd_timing;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  // d_*: default timing, PIPE_DELAY=0. a_*: small timing, PIPE_DELAY=0.
  // b_*: small timing, PIPE_DELAY=1.
  // Small timing: H 2/3/8/4 (total 17, active 5..12), V 1/2/5/2 (total 10,
  // active 3..7), frame at line 8, period 170.
  logic d_hs, d_vs, d_de, d_fr;
  logic [9:0] d_x, d_y;
  logic a_hs, a_vs, a_de, a_fr;
  logic [9:0] a_x, a_y;
  logic b_hs, b_vs, b_de, b_fr;
  logic [9:0] b_x, b_y;

  lcd_timing #(.PIPE_DELAY(0)) dut_def (
    .clk(clk), .nrst(nrst), .hsync(d_hs), .vsync(d_vs), .de(d_de),
    .frame(d_fr), .x(d_x), .y(d_y)
  );

  lcd_timing #(
    .H_ACTIVE(8), .H_SYNC(2), .H_BP(3), .H_FP(4),
    .V_ACTIVE(5), .V_SYNC(1), .V_BP(2), .V_FP(2), .PIPE_DELAY(0)
  ) dut_s0 (
    .clk(clk), .nrst(nrst), .hsync(a_hs), .vsync(a_vs), .de(a_de),
    .frame(a_fr), .x(a_x), .y(a_y)
  );

  lcd_timing #(
    .H_ACTIVE(8), .H_SYNC(2), .H_BP(3), .H_FP(4),
    .V_ACTIVE(5), .V_SYNC(1), .V_BP(2), .V_FP(2), .PIPE_DELAY(1)
  ) dut_s1 (
    .clk(clk), .nrst(nrst), .hsync(b_hs), .vsync(b_vs), .de(b_de),
    .frame(b_fr), .x(b_x), .y(b_y)
  );

  int checks = 0;
  int failures = 0;
  int edge_n = 0;
  int pos = -3;

  typedef struct {
    int pos;
    int hs, vs, de, fr, x, y;
    int hs1, vs1, de1;
  } vec_t;
  vec_t vecs[$];

  int hs_run, vs_run, de_run, bursts, fr_run, since_fr;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (pos %0d)", name, act, exp, pos);
    end
  endtask

  task automatic add(input int p, input int hs, input int vs, input int de,
                     input int fr, input int x, input int y,
                     input int hs1, input int vs1, input int de1);
    vec_t v;
    v.pos = p; v.hs = hs; v.vs = vs; v.de = de; v.fr = fr; v.x = x; v.y = y;
    v.hs1 = hs1; v.vs1 = vs1; v.de1 = de1;
    vecs.push_back(v);
  endtask

  task automatic mon_clear();
    hs_run = 0; vs_run = 0; de_run = 0; bursts = 0; fr_run = 0; since_fr = -1;
  endtask

  // Pulse-width / burst / frame-period checks on the small PIPE_DELAY=0 DUT.
  task automatic monitor();
    if (!a_hs) hs_run++;
    else begin
      if (hs_run != 0) chk("hsync_low_width", hs_run, 2);
      hs_run = 0;
    end
    if (!a_vs) vs_run++;
    else begin
      if (vs_run != 0) chk("vsync_low_width", vs_run, 17);
      vs_run = 0;
    end
    if (a_de) begin
      chk("x_in_burst", int'(a_x), de_run);
      chk("y_in_burst", int'(a_y), bursts);
      de_run++;
    end else begin
      if (de_run != 0) begin
        chk("de_burst_len", de_run, 8);
        bursts++;
      end
      de_run = 0;
    end
    if (a_fr) begin
      chk("bursts_per_frame", bursts, 5);
      if (since_fr >= 0) chk("frame_period", since_fr + 1, 170);
      since_fr = 0;
      bursts = 0;
      fr_run++;
    end else begin
      if (fr_run != 0) chk("frame_width", fr_run, 1);
      fr_run = 0;
      if (since_fr >= 0) since_fr++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    pos = edge_n - 3;
    @(negedge clk);
    monitor();
  endtask

  task automatic goto(input int p);
    while (pos < p) tick();
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_def_hs"}, int'(d_hs), 1);
    chk({tag, "_def_vs"}, int'(d_vs), 1);
    chk({tag, "_def_de"}, int'(d_de), 0);
    chk({tag, "_def_fr"}, int'(d_fr), 0);
    chk({tag, "_def_x"}, int'(d_x), 0);
    chk({tag, "_def_y"}, int'(d_y), 0);
    chk({tag, "_s0_hs"}, int'(a_hs), 1);
    chk({tag, "_s0_vs"}, int'(a_vs), 1);
    chk({tag, "_s0_de"}, int'(a_de), 0);
    chk({tag, "_s0_fr"}, int'(a_fr), 0);
    chk({tag, "_s0_x"}, int'(a_x), 0);
    chk({tag, "_s0_y"}, int'(a_y), 0);
    chk({tag, "_s1_hs"}, int'(b_hs), 1);
    chk({tag, "_s1_vs"}, int'(b_vs), 1);
    chk({tag, "_s1_de"}, int'(b_de), 0);
  endtask

  task automatic wait_def_rise(input string tag);
    int rx, ry, rp;
    rp = -1; rx = -1; ry = -1;
    while (rp < 0 && pos < 24400) begin
      tick();
      if (d_de) begin
        rp = pos; rx = int'(d_x); ry = int'(d_y);
      end
    end
    chk({tag, "_def_de_rise_pos"}, rp, 24334);
    chk({tag, "_def_rise_x"}, rx, 0);
    chk({tag, "_def_rise_y"}, ry, 0);
  endtask

  initial begin
    int fr_seen, rise_pos, rise_x, rise_y;

    //   pos  hs vs de fr x  y   hs1 vs1 de1 (PIPE_DELAY=1 sync/de)
    add(0,    0, 0, 0, 0, 0, 0,  1, 1, 0);
    add(1,    0, 0, 0, 0, 0, 0,  0, 0, 0);
    add(2,    1, 0, 0, 0, 0, 0,  0, 0, 0);
    add(3,    1, 0, 0, 0, 0, 0,  1, 0, 0);
    add(16,   1, 0, 0, 0, 0, 0,  1, 0, 0);
    add(17,   0, 1, 0, 0, 0, 0,  1, 0, 0);
    add(18,   0, 1, 0, 0, 0, 0,  0, 1, 0);
    add(56,   1, 1, 1, 0, 0, 0,  1, 1, 0);
    add(57,   1, 1, 1, 0, 1, 0,  1, 1, 1);
    add(63,   1, 1, 1, 0, 7, 0,  1, 1, 1);
    add(64,   1, 1, 0, 0, 0, 0,  1, 1, 1);
    add(65,   1, 1, 0, 0, 0, 0,  1, 1, 0);
    add(92,   1, 1, 1, 0, 2, 2,  1, 1, 1);
    add(135,  1, 1, 0, 0, 0, 0,  1, 1, 0);
    add(136,  0, 1, 0, 1, 0, 0,  1, 1, 0);
    add(137,  0, 1, 0, 0, 0, 0,  0, 1, 0);
    add(169,  1, 1, 0, 0, 0, 0,  1, 1, 0);
    add(170,  0, 0, 0, 0, 0, 0,  1, 1, 0);
    add(171,  0, 0, 0, 0, 0, 0,  0, 0, 0);
    add(226,  1, 1, 1, 0, 0, 0,  1, 1, 0);
    add(306,  0, 1, 0, 1, 0, 0,  1, 1, 0);

    // Reset state
    nrst = 1'b0;
    mon_clear();
    repeat (3) @(negedge clk);
    check_idle("reset");

    // Asynchronous release mid-cycle; two synchroniser edges stay idle
    @(posedge clk);
    #3 nrst = 1'b1;
    edge_n = 0; pos = -3;
    tick();
    check_idle("sync_edge1");
    tick();
    check_idle("sync_edge2");
    tick();
    chk("def_pos0_hs", int'(d_hs), 0);
    chk("def_pos0_vs", int'(d_vs), 0);

    foreach (vecs[i]) begin
      goto(vecs[i].pos);
      chk($sformatf("v%0d_s0_hs", i), int'(a_hs), vecs[i].hs);
      chk($sformatf("v%0d_s0_vs", i), int'(a_vs), vecs[i].vs);
      chk($sformatf("v%0d_s0_de", i), int'(a_de), vecs[i].de);
      chk($sformatf("v%0d_s0_fr", i), int'(a_fr), vecs[i].fr);
      chk($sformatf("v%0d_s0_x", i), int'(a_x), vecs[i].x);
      chk($sformatf("v%0d_s0_y", i), int'(a_y), vecs[i].y);
      chk($sformatf("v%0d_s1_hs", i), int'(b_hs), vecs[i].hs1);
      chk($sformatf("v%0d_s1_vs", i), int'(b_vs), vecs[i].vs1);
      chk($sformatf("v%0d_s1_de", i), int'(b_de), vecs[i].de1);
      chk($sformatf("v%0d_s1_fr", i), int'(b_fr), vecs[i].fr);
      chk($sformatf("v%0d_s1_x", i), int'(b_x), vecs[i].x);
      chk($sformatf("v%0d_s1_y", i), int'(b_y), vecs[i].y);
    end

    // Default timing: hsync 20 wide, vsync 3 lines
    goto(1075);
    chk("def_hs_last_low", int'(d_hs), 0);
    tick();
    chk("def_hs_rise", int'(d_hs), 1);
    goto(3167);
    chk("def_vs_last_low", int'(d_vs), 0);
    tick();
    chk("def_vs_rise", int'(d_vs), 1);

    wait_def_rise("first");
    goto(25133);
    chk("def_last_px_de", int'(d_de), 1);
    chk("def_last_px_x", int'(d_x), 799);
    chk("def_last_px_y", int'(d_y), 0);
    tick();
    chk("def_after_line_de", int'(d_de), 0);
    chk("def_after_line_x", int'(d_x), 0);

    // Mid-frame reset while the default DUT is mid-burst
    goto(25690);
    chk("pre_rst_def_de", int'(d_de), 1);
    chk("pre_rst_def_x", int'(d_x), 300);
    chk("pre_rst_def_y", int'(d_y), 1);
    #2 nrst = 1'b0;
    #1 check_idle("midrst");
    repeat (3) @(negedge clk);
    check_idle("midrst_hold");
    @(posedge clk);
    #3 nrst = 1'b1;
    edge_n = 0; pos = -3;
    mon_clear();

    fr_seen = 0; rise_pos = -1; rise_x = -1; rise_y = -1;
    while (pos < 135) begin
      tick();
      if (a_fr) fr_seen++;
      if (a_de && rise_pos < 0) begin
        rise_pos = pos; rise_x = int'(a_x); rise_y = int'(a_y);
      end
    end
    chk("restart_s0_rise_pos", rise_pos, 56);
    chk("restart_s0_rise_x", rise_x, 0);
    chk("restart_s0_rise_y", rise_y, 0);
    chk("abandoned_frame_pulses", fr_seen, 0);
    tick();
    chk("restart_s0_frame", int'(a_fr), 1);

    wait_def_rise("restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
